// File: rtl/board_iface_pkg.sv
// Shared constants, switch-word layout and lane helpers for the board input front end.
package board_iface_pkg;

   localparam int unsigned LANE_W = 8;
   localparam int unsigned SW_W   = 10;
   localparam int unsigned LED_W  = 9;

   // Encoding of sw[9].
   typedef enum logic {
      MODE_CTRL = 1'b0,
      MODE_DATA = 1'b1
   } mode_e;

   // Slide-switch word as seen by the load logic.
   typedef struct packed {
      mode_e             mode;
      logic              restart;
      logic [LANE_W-1:0] data;
   } sw_t;

   // Number of byte lanes in a datapath word.
   function automatic int unsigned lanes(input int unsigned data_w);
      return data_w / LANE_W;
   endfunction

   // Width of the lane pointer; a single lane still gets one bit.
   function automatic int unsigned lane_idx_w(input int unsigned nlanes);
      return (nlanes <= 32'd1) ? 32'd1 : int'($clog2(nlanes));
   endfunction

endpackage

// File: rtl/step_input_iface_if.sv
// Board-side bundle: raw key/switch inputs and the registered datapath-facing results.
interface step_input_iface_if
   import board_iface_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CTRL_W = 9,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned LW = lane_idx_w(lanes(DATA_W));

   logic              key_n;
   logic [SW_W-1:0]   sw;
   logic              step;
   logic              pressed;
   logic [DATA_W-1:0] datapath_in;
   logic [CTRL_W-1:0] ctrl;
   logic [LW-1:0]     lane_idx;
   logic [CNT_W-1:0]  step_cnt;
   logic [LED_W-1:0]  ledr;

   modport master (
      output key_n, sw,
      input  step, pressed, datapath_in, ctrl, lane_idx, step_cnt, ledr
   );

   modport slave (
      input  key_n, sw,
      output step, pressed, datapath_in, ctrl, lane_idx, step_cnt, ledr
   );

endinterface

// File: rtl/key_debounce.sv
// Push-button synchroniser and debouncer producing a one-cycle press pulse.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic pressed,
   output logic press_pulse
);
   localparam int unsigned  CW       = (DEBOUNCE_CYC <= 32'd2) ? 32'd1 : int'($clog2(DEBOUNCE_CYC));
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 32'd1);

   logic          sync1;
   logic          sync2;
   logic          deb_n;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser; idles at released.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Accept a level change only after it has held for DEBOUNCE_CYC cycles; pulse on press only.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_n       <= 1'b1;
         cnt         <= '0;
         press_pulse <= 1'b0;
      end else begin
         press_pulse <= 1'b0;
         if (sync2 == deb_n) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            deb_n       <= sync2;
            cnt         <= '0;
            press_pulse <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign pressed = ~deb_n;

endmodule

// File: rtl/step_input_iface.sv
// Board input front end: debounced step enable plus lane-wise data and control word loading.
module step_input_iface
   import board_iface_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned CTRL_W       = 9,
   parameter int unsigned DEBOUNCE_CYC = 250000,
   parameter int unsigned CNT_W        = 16
) (
   input logic               clk,
   input logic               reset,
   step_input_iface_if.slave bus
);
   localparam int unsigned    NLANES       = lanes(DATA_W);
   localparam int unsigned    LW           = lane_idx_w(NLANES);
   localparam logic [LW-1:0] LANE_LAST    = LW'(NLANES - 32'd1);
   localparam logic [LW-1:0] LANE_RESTART = LW'(32'd1 % NLANES);

   sw_t               sw_w;
   logic              step_w;
   logic              pressed_w;
   logic [DATA_W-1:0] data_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [LW-1:0]     lane_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [LED_W-1:0]  ledr_c;

   assign sw_w = sw_t'(bus.sw);

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_deb (
      .clk         (clk),
      .reset       (reset),
      .key_n       (bus.key_n),
      .pressed     (pressed_w),
      .press_pulse (step_w)
   );

   // Load registers update only on the edge that closes a step cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         ctrl_q <= '0;
         lane_q <= '0;
         cnt_q  <= '0;
      end else if (step_w) begin
         cnt_q <= cnt_q + 1'b1;
         if (sw_w.mode == MODE_DATA) begin
            if (sw_w.restart) begin
               data_q <= DATA_W'(sw_w.data);
               lane_q <= LANE_RESTART;
            end else begin
               for (int unsigned l = 0; l < NLANES; l++) begin
                  if (lane_q == LW'(l)) begin
                     data_q[l*LANE_W +: LANE_W] <= sw_w.data;
                  end
               end
               lane_q <= (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
            end
         end else begin
            ctrl_q <= CTRL_W'(bus.sw);
         end
      end
   end

   // LED view follows the mode switch live.
   always_comb begin
      ledr_c = {1'b0, data_q[LANE_W-1:0]};
      if (sw_w.mode == MODE_DATA) begin
         ledr_c = LED_W'(ctrl_q);
      end
   end

   assign bus.step        = step_w;
   assign bus.pressed     = pressed_w;
   assign bus.datapath_in = data_q;
   assign bus.ctrl        = ctrl_q;
   assign bus.lane_idx    = lane_q;
   assign bus.step_cnt    = cnt_q;
   assign bus.ledr        = ledr_c;

endmodule

// File: tb/tb_step_input_iface.sv
// Scoreboard bench for step_input_iface: 16-bit and 32-bit instances driven in lockstep.
module tb_step_input_iface;
   import board_iface_pkg::*;

   localparam int unsigned D = 4;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       key_n = 1'b1;
   logic [9:0] sw    = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   step_input_iface_if #(.DATA_W(16), .CTRL_W(9), .CNT_W(16)) bus16 ();
   step_input_iface_if #(.DATA_W(32), .CTRL_W(9), .CNT_W(16)) bus32 ();

   assign bus16.key_n = key_n;
   assign bus16.sw    = sw;
   assign bus32.key_n = key_n;
   assign bus32.sw    = sw;

   step_input_iface #(.DATA_W(16), .CTRL_W(9), .DEBOUNCE_CYC(D), .CNT_W(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16.slave)
   );

   step_input_iface #(.DATA_W(32), .CTRL_W(9), .DEBOUNCE_CYC(D), .CNT_W(16)) dut32 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus32.slave)
   );

   typedef struct packed {
      logic [31:0] d32;
      logic [15:0] d16;
      logic [1:0]  l32;
      logic        l16;
      logic [8:0]  ctrl;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] m_d16;
   logic [31:0] m_d32;
   logic        m_l16;
   logic [1:0]  m_l32;
   logic [8:0]  m_ctrl;
   logic [15:0] m_cnt;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_d16 = '0; m_d32 = '0; m_l16 = '0; m_l32 = '0; m_ctrl = '0; m_cnt = '0;
   endtask

   // Reference behaviour of one accepted press; result queued for the scoreboard.
   task automatic model_step(input logic [9:0] s);
      exp_t e;
      int   sh16;
      int   sh32;
      sh16 = 8 * int'(m_l16);
      sh32 = 8 * int'(m_l32);
      if (s[9]) begin
         if (s[8]) begin
            m_d16 = {8'h00, s[7:0]};
            m_d32 = {24'h0, s[7:0]};
            m_l16 = 1'b1;
            m_l32 = 2'd1;
         end else begin
            m_d16 = (m_d16 & ~(16'h00FF << sh16)) | (16'(s[7:0]) << sh16);
            m_d32 = (m_d32 & ~(32'h000000FF << sh32)) | (32'(s[7:0]) << sh32);
            m_l16 = 1'(32'(int'(m_l16) + 1) % 32'd2);
            m_l32 = 2'(32'(int'(m_l32) + 1) % 32'd4);
         end
      end else begin
         m_ctrl = s[8:0];
      end
      m_cnt = m_cnt + 16'd1;
      e.d32 = m_d32; e.d16 = m_d16; e.l32 = m_l32; e.l16 = m_l16;
      e.ctrl = m_ctrl; e.cnt = m_cnt;
      sb_q.push_back(e);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_step"},  64'(bus16.step), 64'd0);
      check({tag, "_data"},  64'(bus16.datapath_in), 64'd0);
      check({tag, "_ctrl"},  64'(bus16.ctrl), 64'd0);
      check({tag, "_lane"},  64'(bus16.lane_idx), 64'd0);
      check({tag, "_cnt"},   64'(bus16.step_cnt), 64'd0);
      check({tag, "_data32"}, 64'(bus32.datapath_in), 64'd0);
      check({tag, "_cnt32"}, 64'(bus32.step_cnt), 64'd0);
   endtask

   // Press, hold, release; checks latency, single pulse and the scoreboard entry.
   task automatic press(input logic [9:0] s);
      int   lat;
      int   extra;
      exp_t e;
      model_step(s);
      @(negedge clk);
      sw    = s;
      key_n = 1'b0;
      lat   = -1;
      for (int c = 0; c < 20 && lat < 0; c++) begin
         @(negedge clk);
         if (bus16.step) lat = c;
      end
      check("step_latency", 64'(lat), 64'(D + 1));
      check("step32_pulse", 64'(bus32.step), 64'd1);
      @(negedge clk);
      e = sb_q.pop_front();
      check("data16", 64'(bus16.datapath_in), 64'(e.d16));
      check("lane16", 64'(bus16.lane_idx), 64'(e.l16));
      check("data32", 64'(bus32.datapath_in), 64'(e.d32));
      check("lane32", 64'(bus32.lane_idx), 64'(e.l32));
      check("ctrl16", 64'(bus16.ctrl), 64'(e.ctrl));
      check("ctrl32", 64'(bus32.ctrl), 64'(e.ctrl));
      check("cnt16", 64'(bus16.step_cnt), 64'(e.cnt));
      check("cnt32", 64'(bus32.step_cnt), 64'(e.cnt));
      extra = int'(bus16.step);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         extra += int'(bus16.step);
      end
      key_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         extra += int'(bus16.step);
      end
      check("step_single", 64'(extra), 64'd0);
   endtask

   initial begin
      int glitch_steps;
      model_reset();

      // Reset values
      repeat (3) @(negedge clk);
      check_zero("rst");
      reset = 1'b0;
      @(negedge clk);
      check_zero("post_rst");
      check("rst_ledr", 64'(bus16.ledr), 64'd0);

      // Short glitch never reaches the debounce threshold
      key_n = 1'b0;
      repeat (2) @(negedge clk);
      key_n = 1'b1;
      glitch_steps = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         glitch_steps += int'(bus16.step);
      end
      check("glitch_steps", 64'(glitch_steps), 64'd0);
      check("glitch_debcnt", 64'(dut16.u_deb.cnt), 64'd0);
      check("glitch_stepcnt", 64'(bus16.step_cnt), 64'd0);

      // Two data loads fill both lanes of the 16-bit word
      press(10'h2A5);
      press(10'h23C);
      check("t3_data", 64'(bus16.datapath_in), 64'h3CA5);
      check("t3_lane", 64'(bus16.lane_idx), 64'd0);
      check("t3_cnt", 64'(bus16.step_cnt), 64'd2);

      // Control load leaves data alone; LED view follows the mode switch
      press(10'h1F3);
      check("t4_ctrl", 64'(bus16.ctrl), 64'h1F3);
      check("t4_data", 64'(bus16.datapath_in), 64'h3CA5);
      check("t4_ledr_ctrlmode", 64'(bus16.ledr), 64'h0A5);
      @(negedge clk);
      sw = 10'h200;
      #1;
      check("t4_ledr_datamode", 64'(bus16.ledr), 64'h1F3);
      repeat (3) begin
         @(negedge clk);
         sw = 10'(sw + 10'h155);
      end
      @(negedge clk);
      check("hold_cnt", 64'(bus16.step_cnt), 64'd3);
      check("hold_data", 64'(bus16.datapath_in), 64'h3CA5);

      // Restart load clears upper lane and points at lane 1
      press(10'h2A5);
      check("t5_pre_lane", 64'(bus16.lane_idx), 64'd1);
      press(10'h377);
      check("t5_data", 64'(bus16.datapath_in), 64'h0077);
      check("t5_lane", 64'(bus16.lane_idx), 64'd1);

      // Reset in the middle of a debounce drops the press
      @(negedge clk);
      key_n = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_debcnt", 64'(dut16.u_deb.cnt), 64'd2);
      reset = 1'b1;
      key_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      glitch_steps = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         glitch_steps += int'(bus16.step) + int'(bus32.step);
      end
      check("mid_rst_steps", 64'(glitch_steps), 64'd0);
      check_zero("mid_rst");

      // Four loads fill the 32-bit word and wrap its lane pointer
      press(10'h211);
      press(10'h222);
      press(10'h233);
      press(10'h244);
      check("w32_data", 64'(bus32.datapath_in), 64'h44332211);
      check("w32_lane", 64'(bus32.lane_idx), 64'd0);
      check("w32_cnt", 64'(bus32.step_cnt), 64'd4);
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
